// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: DR rising edge -> one FIFO write, FWFT read port.
// Optional macro UART_RX_FIFO_DROP_ERR_EN discards framing-error bytes instead of storing the flag.
module uart_rx_fifo #(
  parameter int pDepthLog2 = 4,
  parameter int pWidth     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [pWidth-1:0]     RX_DATA,
  input  logic                  RX_DR,
  input  logic                  RX_ERR,
  input  logic                  RD,
  input  logic                  OVF_CLR,
  output logic [pWidth-1:0]     DOUT,
  output logic                  DOUT_ERR,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [pDepthLog2:0]   COUNT,
  output logic                  OVF
);

`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam int MemW = pWidth;
`else
  localparam int MemW = pWidth + 1;
`endif
  localparam int Depth = 1 << pDepthLog2;

  logic                  dr_q, dr_d;
  logic [pDepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [pDepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [pDepthLog2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [MemW-1:0]       mem_q [Depth];

  logic [MemW-1:0]       wr_word;
  logic [MemW-1:0]       head;
  logic                  empty, full, wr, store, rd, accept, drop;

  always_comb begin
    empty = (count_q == '0);
    // COUNT never exceeds depth, so its top bit alone marks full
    full  = count_q[pDepthLog2];
    wr    = RX_DR & ~dr_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    store   = wr & ~RX_ERR;
    wr_word = RX_DATA;
`else
    store   = wr;
    wr_word = {RX_ERR, RX_DATA};
`endif
    rd     = RD & ~empty;
    accept = store & (~full | rd);
    drop   = store & full & ~rd;

    dr_d     = RX_DR;
    wr_ptr_d = accept ? wr_ptr_q + pDepthLog2'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + pDepthLog2'(1) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !rd) begin
      count_d = count_q + (pDepthLog2 + 1)'(1);
    end else if (rd && !accept) begin
      count_d = count_q - (pDepthLog2 + 1)'(1);
    end
    // a fresh overflow beats a clear in the same cycle
    ovf_d = drop | (ovf_q & ~OVF_CLR);
    head  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dr_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dr_q     <= dr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && !RST) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign EMPTY = empty;
  assign FULL  = full;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign DOUT     = empty ? '0 : head;
  assign DOUT_ERR = 1'b0;
`else
  assign DOUT     = empty ? '0 : head[pWidth-1:0];
  assign DOUT_ERR = ~empty & head[pWidth];
`endif

endmodule
